// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_stream_pkg: shared types and sizes for the FIFO stream reader.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fifo_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int BUF_DEPTH          = 2;
  localparam int CNT_W              = 16;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/stream_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_skid_buf: 2-entry register FIFO with independent push/pop.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic                  head;
  logic                  tail;

  // Separate head/tail pointers keep order intact when push and pop coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_stream_reader: drains synchronous_fifo into a valid/ready       |
// | stream. Optional m_last framing when STREAM_LAST_EN is defined.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_W-1:0]      word_cnt
);

  logic [1:0] occ;
  logic       inflight;
  logic       pop;
  logic [1:0] credit_used;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  // pop never exceeds occ, so this cannot underflow; max value is BUF_DEPTH.
  assign credit_used = occ + {1'b0, inflight} - {1'b0, pop};
  assign fifo_r_en   = !rst_n && !fifo_empty && (credit_used < 2'(BUF_DEPTH));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      inflight <= fifo_r_en;
      if (pop) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst_n),
    .push      (inflight),
    .push_data (fifo_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

`ifdef STREAM_LAST_EN
  localparam int BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [BURST_W-1:0] burst_idx;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      burst_idx <= '0;
    end else if (pop) begin
      if (burst_idx == BURST_W'(BURST_LEN - 1)) begin
        burst_idx <= '0;
      end else begin
        burst_idx <= burst_idx + 1'b1;
      end
    end
  end

  assign m_last = m_valid && (burst_idx == BURST_W'(BURST_LEN - 1));
`else
  // Framing disabled: the term is constant 0 for any legal BURST_LEN.
  assign m_last = m_valid && (BURST_LEN == 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// Directed bench for fifo_stream_reader with a behavioural 1-cycle-latency FIFO model.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty;
  logic       fifo_r_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       m_last;
  logic [15:0] word_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] fmem [128];
  int wr_ptr = 0;
  int rd_ptr = 0;

  logic [7:0] rx_q[$];
  logic       last_q[$];
  int         rd_pulses = 0;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;

  fifo_stream_reader #(
    .DATA_WIDTH (8),
    .BURST_LEN  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read port model: data appears the cycle after r_en.
  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_data <= fmem[rd_ptr % 128];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Mid-cycle monitor: invariants, hold stability, transfer capture.
  always @(negedge clk) begin
    if (rst_n !== 1'b0) begin
      hold_pending = 1'b0;
    end else begin
      n_vec++;
      if (int'(dut.occ) + int'(dut.inflight) > 2) begin
        n_err++;
        $display("FAIL credit: occ+inflight=%0d, required <=2", int'(dut.occ) + int'(dut.inflight));
      end
      n_vec++;
      if (fifo_r_en && fifo_empty) begin
        n_err++;
        $display("FAIL underflow: fifo_r_en=1 while fifo_empty=1, required fifo_r_en=0");
      end
      if (hold_pending) begin
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== hold_data || m_last !== hold_last) begin
          n_err++;
          $display("FAIL hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   m_valid, m_data, m_last, hold_data, hold_last);
        end
      end
      if (fifo_r_en) rd_pulses++;
      if (m_valid && m_ready) begin
        rx_q.push_back(m_data);
        last_q.push_back(m_last);
      end
      hold_pending = m_valid && !m_ready;
      hold_data    = m_data;
      hold_last    = m_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] v);
    fmem[wr_ptr % 128] = v;
    wr_ptr++;
  endtask

  task automatic do_reset();
    tick(1);
    rst_n   = 1'b1;
    m_ready = 1'b0;
    wr_ptr  = rd_ptr;
    tick(2);
    rst_n = 1'b0;
    rx_q.delete();
    last_q.delete();
    rd_pulses = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    push_word(8'h5A);
    tick(2);
    n_vec++; if (fifo_r_en !== 1'b0) begin n_err++; $display("FAIL rst_r_en: got %b, required 0", fifo_r_en); end
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, required 0", m_valid); end
    n_vec++; if (word_cnt !== 16'h0) begin n_err++; $display("FAIL rst_cnt: got %h, required 0000", word_cnt); end
    n_vec++; if (m_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h, required 00", m_data); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (fifo_r_en !== 1'b1) begin n_err++; $display("FAIL release_r_en: got %b, required 1", fifo_r_en); end
    tick(1);
    n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL latency_clk1: valid=%b, required 0", m_valid); end
    tick(1);
    n_vec++; if (m_valid !== 1'b1 || m_data !== 8'h5A) begin
      n_err++; $display("FAIL latency_clk2: valid=%b data=%h, required valid=1 data=5a", m_valid, m_data);
    end
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    n_vec++; if (word_cnt !== 16'd1 || m_valid !== 1'b0) begin
      n_err++; $display("FAIL first_pop: cnt=%0d valid=%b, required cnt=1 valid=0", word_cnt, m_valid);
    end
  endtask

  task automatic test_streaming();
    bit got;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'(8'h11 + i));
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid) begin got = 1'b1; break; end
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL stream_start: valid=0 after 10 clks, required 1"); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++;
      if (m_valid !== 1'b1 || m_data !== 8'(8'h11 + i)) begin
        n_err++; $display("FAIL stream_word%0d: valid=%b data=%h, required valid=1 data=%h",
                          i, m_valid, m_data, 8'(8'h11 + i));
      end
    end
    @(negedge clk);
    n_vec++; if (m_valid !== 1'b0 || word_cnt !== 16'd8) begin
      n_err++; $display("FAIL stream_end: valid=%b cnt=%0d, required valid=0 cnt=8", m_valid, word_cnt);
    end
    tick(1);
    m_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] got_v;
    do_reset();
    for (int i = 0; i < 4; i++) push_word(8'(8'h21 + i));
    tick(10);
    n_vec++; if (rd_pulses != 2) begin n_err++; $display("FAIL bp_reads: got %0d r_en pulses, required 2", rd_pulses); end
    n_vec++; if (m_valid !== 1'b1 || m_data !== 8'h21) begin
      n_err++; $display("FAIL bp_head: valid=%b data=%h, required valid=1 data=21", m_valid, m_data);
    end
    m_ready = 1'b1;
    tick(10);
    m_ready = 1'b0;
    n_vec++; if (rx_q.size() != 4) begin n_err++; $display("FAIL bp_count: got %0d words, required 4", rx_q.size()); end
    for (int i = 0; i < 4; i++) begin
      got_v = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_vec++;
      if (got_v !== 8'(8'h21 + i)) begin
        n_err++; $display("FAIL bp_word%0d: got %h, required %h", i, got_v, 8'(8'h21 + i));
      end
    end
    n_vec++; if (word_cnt !== 16'd4 || rd_pulses != 4) begin
      n_err++; $display("FAIL bp_totals: cnt=%0d reads=%0d, required cnt=4 reads=4", word_cnt, rd_pulses);
    end
  endtask

  task automatic test_empty_edge();
    do_reset();
    push_word(8'hA5);
    tick(6);
    n_vec++; if (rd_pulses != 1) begin n_err++; $display("FAIL edge_reads: got %0d, required 1", rd_pulses); end
    n_vec++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      n_err++; $display("FAIL edge_word: valid=%b data=%h, required valid=1 data=a5", m_valid, m_data);
    end
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    tick(3);
    n_vec++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      n_err++; $display("FAIL edge_rx: got %0d words, required 1 word a5", rx_q.size());
    end
    n_vec++; if (m_valid !== 1'b0 || word_cnt !== 16'd1 || rd_pulses != 1) begin
      n_err++; $display("FAIL edge_after: valid=%b cnt=%0d reads=%0d, required valid=0 cnt=1 reads=1",
                        m_valid, word_cnt, rd_pulses);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'(8'h31 + i));
    tick(5);
    n_vec++; if (!(m_valid === 1'b1 && dut.inflight === 1'b1)) begin
      n_err++; $display("FAIL mid_state: valid=%b inflight=%b, required 1 and 1", m_valid, dut.inflight);
    end
    rst_n = 1'b1;
    #1;
    n_vec++; if (m_valid !== 1'b0 || fifo_r_en !== 1'b0) begin
      n_err++; $display("FAIL mid_async: valid=%b r_en=%b, required 0 and 0", m_valid, fifo_r_en);
    end
    n_vec++; if (word_cnt !== 16'h0 || m_data !== 8'h00) begin
      n_err++; $display("FAIL mid_clear: cnt=%h data=%h, required 0000 and 00", word_cnt, m_data);
    end
    wr_ptr = rd_ptr;
    tick(2);
    rst_n = 1'b0;
    rx_q.delete();
    last_q.delete();
    push_word(8'hC1);
    push_word(8'hC2);
    tick(8);
    n_vec++; if (rx_q.size() != 2 || rx_q[0] !== 8'hC1 || rx_q[1] !== 8'hC2) begin
      n_err++; $display("FAIL mid_fresh: got %0d words first=%h, required 2 words c1,c2",
                        rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    n_vec++; if (word_cnt !== 16'd2) begin n_err++; $display("FAIL mid_cnt: got %0d, required 2", word_cnt); end
    m_ready = 1'b0;
  endtask

  task automatic test_last();
    logic exp_last;
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'(8'h41 + i));
    for (int c = 0; c < 30; c++) begin
      m_ready = c[0];
      tick(1);
    end
    m_ready = 1'b0;
    n_vec++; if (rx_q.size() != 8) begin n_err++; $display("FAIL last_count: got %0d words, required 8", rx_q.size()); end
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
`ifdef STREAM_LAST_EN
      exp_last = (i == 3) || (i == 7);
`else
      exp_last = 1'b0;
`endif
      n_vec++;
      if (rx_q[i] !== 8'(8'h41 + i) || last_q[i] !== exp_last) begin
        n_err++; $display("FAIL last_word%0d: data=%h last=%b, required data=%h last=%b",
                          i, rx_q[i], last_q[i], 8'(8'h41 + i), exp_last);
      end
    end
    n_vec++; if (m_last !== 1'b0) begin n_err++; $display("FAIL last_idle: got %b, required 0", m_last); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_edge();
    test_reset_mid();
    test_last();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
